poly_reduce_seq: RTL and testbench

//   Serial replacement for the 256-lane combinational poly reduction: sequences ONE

---
 rtl/poly_reduce_seq_if.sv | 56 +++++
 rtl/poly_reduce_seq.sv | 139 +++++++++++++
 tb/tb_poly_reduce_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_reduce_seq_if.sv
// poly_reduce_seq_if
//   Bundles the sequencer handshake (start/abort/busy/done) and the shared
//   coefficient-RAM port used by poly_reduce_seq.
//   master : the reducer side; it drives the RAM read/write requests and the
//            busy/done status.
//   slave  : the environment side (sequencer + RAM arbiter/RAM); it drives
//            start, abort, mem_gnt and the returned read data.
//   Signals:
//     start, abort       sequencer -> reducer
//     busy, done         reducer -> sequencer
//     mem_gnt            read grant for the current cycle
//     mem_rd_en/addr     read request, data returns one cycle later on mem_rd_data
//     mem_wr_en/addr/data  write strobe, never stalled
interface poly_reduce_seq_if #(
    parameter int ADDR_W = 8
);
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                mem_gnt;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic signed [31:0]  mem_rd_data;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic signed [31:0]  mem_wr_data;

    modport master (
        input  start,
        input  abort,
        input  mem_gnt,
        input  mem_rd_data,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        output start,
        output abort,
        output mem_gnt,
        output mem_rd_data,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/poly_reduce_seq.sv
// poly_reduce_seq
//   Serial in-place polynomial reduction. One reduce32 datapath walks the
//   coefficient RAM: read coeff i, reduce it, write it back to address i.
//   Read -> write latency is fixed at two cycles; grant bubbles travel
//   through the pipeline unchanged, so writes stay in ascending order and a
//   write to i always follows the read of i.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    poly_reduce_seq_if.master (handshake + RAM port)
//   reduce32: t = (a + 2^22) >>> 23, r = a - t*Q, 32-bit wrapping arithmetic.
module poly_reduce_seq #(
    parameter int N      = 256,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    poly_reduce_seq_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [31:0] Q    = 32'sd8380417;
    localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(N - 1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;

    // Stage 1: read issued last cycle, data now on mem_rd_data.
    logic               s1_vld_q;
    logic [ADDR_W-1:0]  s1_addr_q;
    // Stage 2: reduced result, presented as the write.
    logic               s2_vld_q;
    logic [ADDR_W-1:0]  s2_addr_q;
    logic signed [31:0] s2_data_q;

    logic               active;
    logic               kill;
    logic               rd_fire;
    logic               last_rd;
    logic               last_wr;
    logic signed [31:0] red_t;
    logic signed [31:0] red_prod;
    logic signed [31:0] red_r;

    assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign kill    = active && bus.abort;
    // No read in the abort cycle so nothing new enters the pipeline.
    assign rd_fire = (state_q == S_RUN) && bus.mem_gnt && !bus.abort;
    assign last_rd = rd_fire && (rd_ptr_q == LAST);
    assign last_wr = s2_vld_q && (wr_cnt_q == LAST);

    always_comb begin
        red_t    = (bus.mem_rd_data + 32'sd4194304) >>> 23;
        red_prod = red_t * Q;
        red_r    = bus.mem_rd_data - red_prod;
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    rd_ptr_d = '0;
                    wr_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
                if (s2_vld_q) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                end
                if (last_rd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (s2_vld_q) begin
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                end
                if (last_wr) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (kill) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_cnt_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_cnt_q  <= wr_cnt_d;
            s1_vld_q  <= rd_fire;
            s1_addr_q <= rd_ptr_q;
            s2_vld_q  <= s1_vld_q && !kill;
            s2_addr_q <= s1_addr_q;
            // Hold the last result across bubbles so wr_data only moves on real writes.
            if (s1_vld_q) begin
                s2_data_q <= red_r;
            end
        end
    end

    assign bus.busy        = active;
    assign bus.done        = (state_q == S_DONE);
    assign bus.mem_rd_en   = rd_fire;
    assign bus.mem_rd_addr = rd_ptr_q;
    assign bus.mem_wr_en   = s2_vld_q;
    assign bus.mem_wr_addr = s2_addr_q;
    assign bus.mem_wr_data = s2_data_q;

endmodule

// File: tb/tb_poly_reduce_seq.sv
// tb_poly_reduce_seq
//   Drives poly_reduce_seq against a behavioural RAM. Every read the DUT issues
//   pushes the expected write (address, reduced value, due cycle) to a queue;
//   every write pops and compares. Final RAM contents are checked separately.
module tb_poly_reduce_seq;
    localparam int N      = 256;
    localparam int ADDR_W = 8;
    localparam logic signed [31:0] Q = 32'sd8380417;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc_due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    poly_reduce_seq_if #(.ADDR_W(ADDR_W)) bus ();

    poly_reduce_seq #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [31:0] ram  [N];
    logic signed [31:0] orig [N];
    exp_t q[$];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int gmode = 0;
    int exp_rd = 0;
    int wr_count = 0;
    int done_count = 0;
    int done_rel = 0;
    logic rd_allowed = 1'b0;
    logic busy_chk = 1'b0;

    logic              rd_en_s = 1'b0;
    logic [ADDR_W-1:0] rd_addr_s = '0;
    logic              wr_en_s = 1'b0;
    logic [ADDR_W-1:0] wr_addr_s = '0;
    logic [31:0]       wr_data_s = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    function automatic logic signed [31:0] reduce32(input logic signed [31:0] a);
        logic signed [31:0] t;
        t = (a + 32'sd4194304) >>> 23;
        return a - t * Q;
    endfunction

    function automatic logic pick_gnt();
        if (gmode == 0) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic monitor();
        int   rel;
        exp_t e;
        rel = cyc - t0;
        if (bus.mem_rd_en) begin
            check("rd_gnt", 32'(bus.mem_gnt), 32'd1);
            if (!rd_allowed) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_rd));
                if (gmode == 0) check("rd_cycle", 32'(rel), 32'(exp_rd + 1));
                e.addr    = bus.mem_rd_addr;
                e.data    = reduce32(ram[bus.mem_rd_addr]);
                e.cyc_due = cyc + 2;
                q.push_back(e);
                exp_rd++;
            end
        end
        if (bus.mem_wr_en) begin
            if (q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(bus.mem_wr_addr), 32'(e.addr));
                check("wr_data", bus.mem_wr_data, e.data);
                check("wr_latency", 32'(cyc), 32'(e.cyc_due));
                wr_count++;
            end
        end
        if (bus.done) begin
            done_count++;
            done_rel = rel;
            rd_allowed = 1'b0;
        end
        if (busy_chk) begin
            check("busy", 32'(bus.busy), 32'((rel >= 1) && (rel <= N + 2)));
        end
    endtask

    // One clock: apply last cycle's RAM effects, drive inputs, then sample at negedge.
    task automatic cycle(input logic s, input logic g, input logic a);
        @(posedge clk);
        cyc++;
        if (wr_en_s) ram[wr_addr_s] = wr_data_s;
        #1;
        if (rd_en_s) bus.mem_rd_data = ram[rd_addr_s];
        else         bus.mem_rd_data = $urandom;
        bus.start   = s;
        bus.mem_gnt = g;
        bus.abort   = a;
        @(negedge clk);
        rd_en_s   = bus.mem_rd_en;
        rd_addr_s = bus.mem_rd_addr;
        wr_en_s   = bus.mem_wr_en;
        wr_addr_s = bus.mem_wr_addr;
        wr_data_s = bus.mem_wr_data;
        monitor();
    endtask

    task automatic begin_pass(input int mode);
        gmode      = mode;
        exp_rd     = 0;
        wr_count   = 0;
        done_count = 0;
        done_rel   = -1;
        q.delete();
        rd_allowed = 1'b1;
        busy_chk   = (mode == 0);
        for (int i = 0; i < N; i++) orig[i] = ram[i];
        t0 = cyc + 1;
        cycle(1'b1, pick_gnt(), 1'b0);
    endtask

    task automatic run_pass(input int mode, input int abort_at, input logic hold);
        int   rn;
        int   rel;
        int   stop_rel;
        logic aborted;
        logic s;
        aborted  = 1'b0;
        stop_rel = -1;
        check("idle_before", 32'(bus.busy), 32'd0);
        begin_pass(mode);
        forever begin
            rn = cyc + 1 - t0;
            if (!aborted && done_count == 0) s = hold ? 1'b1 : ($urandom_range(0, 7) == 0);
            else                             s = 1'b0;
            cycle(s, pick_gnt(), rn == abort_at);
            rel = cyc - t0;
            if (rel == abort_at) begin
                q.delete();
                rd_allowed = 1'b0;
                busy_chk   = 1'b0;
                aborted    = 1'b1;
                stop_rel   = rel + 20;
            end else if (aborted && rel == abort_at + 1) begin
                check("abort_busy", 32'(bus.busy), 32'd0);
            end
            if (done_count > 0 && stop_rel < 0) stop_rel = rel + 3;
            if (stop_rel >= 0 && rel >= stop_rel) break;
            if (rel > 4000) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
        end
        busy_chk = 1'b0;
        if (abort_at < 0) begin
            check("done_count", 32'(done_count), 32'd1);
            check("wr_count", 32'(wr_count), 32'(N));
            check("rd_count", 32'(exp_rd), 32'(N));
            if (mode == 0) check("done_cycle", 32'(done_rel), 32'(N + 3));
        end else begin
            check("abort_no_done", 32'(done_count), 32'd0);
        end
    endtask

    task automatic check_ram(input string tag, input int nred);
        int bad;
        logic signed [31:0] e;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            e = (i < nred) ? reduce32(orig[i]) : orig[i];
            if (ram[i] !== e) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) ram[i] = $urandom;
    endtask

    initial begin
        int nz;
        int out_rng;
        int not_cong;
        longint d;

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rd_data = '0;
        for (int i = 0; i < N; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en}), 32'd0);
        check("rst_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        check("rst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        check("rst_wr_data", bus.mem_wr_data, 32'd0);
        rst_n = 1'b1;

        // Multiples of Q reduce to zero; exact cycle timing with gnt held high.
        for (int i = 0; i < N; i++) ram[i] = 32'(i) * Q;
        run_pass(0, -1, 1'b0);
        nz = 0;
        for (int i = 0; i < N; i++) if (ram[i] != 0) nz++;
        check("mulq_zero", 32'(nz), 32'd0);

        // Known values at scattered addresses, bounded inputs elsewhere; start held high.
        for (int i = 0; i < N; i++)
            ram[i] = 32'($urandom_range(32'd0, 32'd4286578686)) - 32'sd2143289343;
        ram[3]   = -32'sd1;
        ram[77]  = 32'sd8380417;
        ram[128] = 32'sd4194304;
        ram[200] = 32'sd12574721;
        ram[255] = 32'sd2143289343;
        run_pass(0, -1, 1'b1);
        check("val_m1", ram[3], -32'sd1);
        check("val_q", ram[77], 32'sd0);
        check("val_2p22", ram[128], -32'sd4186113);
        check("val_q_2p22", ram[200], 32'sd4194304);
        check("val_max", ram[255], 32'sd6283008);
        check_ram("ram_bounded", N);
        out_rng  = 0;
        not_cong = 0;
        for (int i = 0; i < N; i++) begin
            if (ram[i] < -32'sd6283009 || ram[i] > 32'sd6283008) out_rng++;
            d = longint'(ram[i]) - longint'(orig[i]);
            if (d % 64'sd8380417 != 0) not_cong++;
        end
        check("range", 32'(out_rng), 32'd0);
        check("congruent", 32'(not_cong), 32'd0);

        // Random grant, random start pulses while busy.
        fill_random();
        run_pass(1, -1, 1'b0);
        check_ram("ram_rand_gnt", N);

        // Abort at cycle 100: addresses 0..97 written, nothing after.
        fill_random();
        run_pass(0, 100, 1'b0);
        check_ram("ram_abort", 98);
        run_pass(0, -1, 1'b0);
        check_ram("ram_after_abort", N);

        // Asynchronous reset between edges in the middle of a pass.
        fill_random();
        begin_pass(0);
        repeat (49) cycle(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ctrl", 32'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en}), 32'd0);
        check("arst_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        check("arst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        check("arst_wr_data", bus.mem_wr_data, 32'd0);
        busy_chk = 1'b0;
        rd_en_s  = 1'b0;
        wr_en_s  = 1'b0;
        q.delete();
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        run_pass(0, -1, 1'b0);
        check_ram("ram_after_rst", N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
